mandelbrot_pixel_scheduler: RTL and testbench

Dispatches the pixels of one frame, in raster order, across `NUM_UNITS` parallel iteration-calculator units. It collects their iteration counts and re-emits them in strict raster order over a valid/ready stream. The block sits between the plot-settings/resolution logic and the output/VGA-memory writer, and replaces lock-step set rendering with per-unit scheduling.

---
 rtl/mandelbrot_pixel_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_mandelbrot_pixel_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mandelbrot_pixel_scheduler.sv
// Raster-order pixel dispatcher for NUM_UNITS iteration units; collects the
// per-unit iteration counts and re-emits them in raster order on a stream.
module mandelbrot_pixel_scheduler #(
  parameter int NUM_UNITS = 4,
  parameter int HBI       = 32
) (
  input  logic                     CLK,
  input  logic                     SYS_RESET_N,
  input  logic                     frame_start,
  input  logic                     abort,
  input  logic [10:0]              x_size,
  input  logic [10:0]              y_size,
  output logic [NUM_UNITS-1:0]     unit_start,
  output logic [NUM_UNITS*12-1:0]  unit_x,
  output logic [NUM_UNITS*12-1:0]  unit_y,
  input  logic [NUM_UNITS-1:0]     unit_done,
  input  logic [NUM_UNITS*HBI-1:0] unit_iter,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [HBI-1:0]           out_data,
  output logic                     out_last,
  output logic                     busy,
  output logic                     frame_done,
  output logic [1:0]               top_state
);

  localparam int IW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2} top_t;
  typedef enum logic [1:0] {U_FREE = 2'd0, U_BUSY = 2'd1, U_HELD = 2'd2} unit_t;

  top_t            state_q, state_d;
  unit_t           ustate_q [NUM_UNITS];
  logic            fresh_q  [NUM_UNITS];
  logic [HBI-1:0]  result_q [NUM_UNITS];
  logic [11:0]     cx_q     [NUM_UNITS];
  logic [11:0]     cy_q     [NUM_UNITS];
  logic [10:0]     xsz_q, x_q, y_q;
  logic [20:0]     total_q, issued_q, emitted_q;
  logic [IW-1:0]   ip_q, op_q;
  logic            frame_done_q;

  logic [20:0]     size_total;
  logic            accept, issue, handshake, last_hs;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == IW'(NUM_UNITS - 1)) ? '0 : i + 1'b1;
  endfunction

  assign size_total = 21'(x_size) * 21'(y_size);
  assign accept     = (state_q == ST_IDLE) && frame_start && !abort;
  assign issue      = (state_q == ST_RUN) && (issued_q != total_q) && (ustate_q[ip_q] == U_FREE);

  // Stream: a beat transfers on a rising edge where out_valid && out_ready;
  // while out_valid is high and out_ready low, out_data/out_last hold.
  assign out_valid  = (state_q != ST_IDLE) && (ustate_q[op_q] == U_HELD);
  assign handshake  = out_valid && out_ready;
  assign last_hs    = handshake && (emitted_q == total_q - 21'd1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept && size_total != '0) state_d = ST_RUN;
      ST_RUN: begin
        if (last_hs)                   state_d = ST_IDLE;
        else if (issued_q == total_q)  state_d = ST_DRAIN;
      end
      ST_DRAIN: if (last_hs) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  always_ff @(posedge CLK or negedge SYS_RESET_N) begin
    if (!SYS_RESET_N) begin
      state_q      <= ST_IDLE;
      xsz_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      total_q      <= '0;
      issued_q     <= '0;
      emitted_q    <= '0;
      ip_q         <= '0;
      op_q         <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_done_q <= 1'b0;
      if (abort) begin
        x_q       <= '0;
        y_q       <= '0;
        total_q   <= '0;
        issued_q  <= '0;
        emitted_q <= '0;
        ip_q      <= '0;
        op_q      <= '0;
      end else if (accept) begin
        xsz_q        <= x_size;
        total_q      <= size_total;
        x_q          <= '0;
        y_q          <= '0;
        issued_q     <= '0;
        emitted_q    <= '0;
        ip_q         <= '0;
        op_q         <= '0;
        frame_done_q <= (size_total == '0);
      end else begin
        if (issue) begin
          ip_q     <= next_idx(ip_q);
          issued_q <= issued_q + 21'd1;
          if (x_q == xsz_q - 11'd1) begin
            x_q <= '0;
            y_q <= y_q + 11'd1;
          end else begin
            x_q <= x_q + 11'd1;
          end
        end
        if (handshake) begin
          op_q      <= next_idx(op_q);
          emitted_q <= emitted_q + 21'd1;
        end
        if (last_hs) frame_done_q <= 1'b1;
      end
    end
  end

  // fresh_q blanks unit_done for the cycle after a start, when the unit may
  // still be presenting the previous job's done level.
  always_ff @(posedge CLK or negedge SYS_RESET_N) begin
    if (!SYS_RESET_N) begin
      for (int k = 0; k < NUM_UNITS; k++) begin
        ustate_q[k] <= U_FREE;
        fresh_q[k]  <= 1'b0;
        result_q[k] <= '0;
        cx_q[k]     <= '0;
        cy_q[k]     <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_UNITS; k++) begin
        fresh_q[k] <= 1'b0;
        if (abort) begin
          ustate_q[k] <= U_FREE;
        end else begin
          case (ustate_q[k])
            U_FREE: if (issue && ip_q == IW'(k)) begin
              ustate_q[k] <= U_BUSY;
              fresh_q[k]  <= 1'b1;
              cx_q[k]     <= {1'b0, x_q};
              cy_q[k]     <= {1'b0, y_q};
            end
            U_BUSY: if (!fresh_q[k] && unit_done[k]) begin
              result_q[k] <= unit_iter[k*HBI +: HBI];
              ustate_q[k] <= U_HELD;
            end
            U_HELD: if (handshake && op_q == IW'(k)) ustate_q[k] <= U_FREE;
            default: ustate_q[k] <= U_FREE;
          endcase
        end
      end
    end
  end

  always_comb begin
    unit_start = '0;
    unit_x     = '0;
    unit_y     = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      unit_start[k]      = issue && (ip_q == IW'(k));
      unit_x[k*12 +: 12] = unit_start[k] ? {1'b0, x_q} : cx_q[k];
      unit_y[k*12 +: 12] = unit_start[k] ? {1'b0, y_q} : cy_q[k];
    end
  end

  assign out_data   = result_q[op_q];
  assign out_last   = out_valid && (emitted_q == total_q - 21'd1);
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = frame_done_q;
  assign top_state  = state_q;

endmodule

// File: tb/tb_mandelbrot_pixel_scheduler.sv
// Bench for mandelbrot_pixel_scheduler: behavioural calculator units, a raster
// reference queue and a stream monitor that checks order, data and last.
module tb_mandelbrot_pixel_scheduler;

  localparam int NU  = 4;
  localparam int HBI = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_start = 1'b0;
  logic abort = 1'b0;
  logic out_ready = 1'b0;
  logic [10:0] x_size = '0;
  logic [10:0] y_size = '0;
  logic [NU-1:0] unit_done = '0;
  logic [NU*HBI-1:0] unit_iter = '0;
  logic [NU-1:0] unit_start;
  logic [NU*12-1:0] unit_x, unit_y;
  logic out_valid, out_last, busy, frame_done;
  logic [HBI-1:0] out_data;
  logic [1:0] top_state;

  int errors = 0;
  int checks = 0;
  logic [HBI:0] exp_q[$];
  logic [HBI:0] mon_e, hold_val;
  int cur_xs = 1;
  int salt = 0;
  int jobs[NU], emits[NU], cnt[NU], jx[NU], jy[NU], lat_fixed[NU];
  bit lat_rand = 0;
  int lat_lo = 1, lat_hi = 1;
  bit rand_ready = 0;
  int start_count = 0, out_count = 0, fd_count = 0;
  bit fd_expect = 0, hold_pending = 0;

  mandelbrot_pixel_scheduler #(.NUM_UNITS(NU), .HBI(HBI)) dut (
    .CLK(clk), .SYS_RESET_N(rst_n), .frame_start(frame_start), .abort(abort),
    .x_size(x_size), .y_size(y_size), .unit_start(unit_start), .unit_x(unit_x),
    .unit_y(unit_y), .unit_done(unit_done), .unit_iter(unit_iter),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .frame_done(frame_done), .top_state(top_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [HBI-1:0] ref_iter(input int x, input int y);
    return HBI'(x + 10 * y + salt * 1000);
  endfunction

  // calculator units: result after a latency, done held until the next start
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      for (int k = 0; k < NU; k++) cnt[k] = 0;
      unit_done = '0;
      unit_iter = '0;
    end else begin
      for (int k = 0; k < NU; k++) begin
        if (unit_start[k]) begin
          chk($sformatf("unit%0d_x", k), 64'(unit_x[k*12 +: 12]), 64'((jobs[k] * NU + k) % cur_xs));
          chk($sformatf("unit%0d_y", k), 64'(unit_y[k*12 +: 12]), 64'((jobs[k] * NU + k) / cur_xs));
          chk("no_reissue_while_held", 64'(emits[k]), 64'(jobs[k]));
          jx[k] = int'(unit_x[k*12 +: 12]);
          jy[k] = int'(unit_y[k*12 +: 12]);
          jobs[k]++;
          start_count++;
          cnt[k] = lat_rand ? int'($urandom_range(lat_hi, lat_lo)) : lat_fixed[k];
          unit_done[k] = 1'b0;
        end else if (cnt[k] > 0) begin
          cnt[k]--;
          if (cnt[k] == 0) begin
            unit_done[k] = 1'b1;
            unit_iter[k*HBI +: HBI] = ref_iter(jx[k], jy[k]);
          end
        end
      end
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pending = 0;
      fd_expect = 0;
    end else begin
      if (frame_done) fd_count++;
      if (fd_expect) begin
        chk("frame_done_after_last", 64'(frame_done), 64'd1);
        chk("busy_low_with_frame_done", 64'(busy), 64'd0);
        fd_expect = 0;
      end
      if (hold_pending) begin
        chk("stall_hold", 64'({out_valid, out_last, out_data}), 64'({1'b1, hold_val}));
        hold_pending = 0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got 0x%0h with no pixel pending", out_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_data", 64'(out_data), 64'(mon_e[HBI-1:0]));
          chk("out_last", 64'(out_last), 64'(mon_e[HBI]));
          if (mon_e[HBI]) fd_expect = 1;
        end
        emits[out_count % NU]++;
        out_count++;
      end else if (out_valid) begin
        hold_pending = 1;
        hold_val = {out_last, out_data};
      end
    end
  end

  // driver tasks
  task automatic start_frame(input int xs, input int ys);
    for (int p = 0; p < xs * ys; p++)
      exp_q.push_back({(p == xs * ys - 1), ref_iter(p % xs, p / xs)});
    cur_xs = (xs == 0) ? 1 : xs;
    out_count = 0;
    start_count = 0;
    for (int k = 0; k < NU; k++) begin
      jobs[k] = 0;
      emits[k] = 0;
    end
    x_size = 11'(xs);
    y_size = 11'(ys);
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic wait_frame(input string name);
    int f0;
    int n;
    f0 = fd_count;
    n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: busy still 1 after %0d cycles, required 0", name, n);
    end
    repeat (2) @(negedge clk);
    chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_frame_done_once"}, 64'(fd_count - f0), 64'd1);
  endtask

  task automatic set_lat(input int l0, input int l1, input int l2, input int l3);
    lat_fixed[0] = l0;
    lat_fixed[1] = l1;
    lat_fixed[2] = l2;
    lat_fixed[3] = l3;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    int s0, f0, v;
    set_lat(3, 3, 3, 3);
    rst_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_unit_start", 64'(unit_start), 64'd0);
    chk("rst_unit_x", 64'(unit_x), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // basic 4x2: 0,1,2,3,10,11,12,13
    salt = 0;
    start_frame(4, 2);
    chk("first_start_onehot", 64'(unit_start), 64'd1);
    chk("first_start_x", 64'(unit_x[11:0]), 64'd0);
    wait_frame("basic");

    // out-of-order completion
    set_lat(20, 2, 2, 2);
    salt = 1;
    start_frame(4, 2);
    repeat (15) @(posedge clk); #1;
    chk("ooo_no_early_output", 64'(out_count), 64'd0);
    wait_frame("ooo");

    // backpressure
    lat_rand = 1; lat_lo = 1; lat_hi = 4;
    salt = 3;
    start_frame(8, 4);
    v = 0;
    while (out_count < 6 && v < 500) begin @(negedge clk); v++; end
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (30) @(posedge clk);
    s0 = start_count;
    repeat (20) @(posedge clk); #1;
    chk("stalled_no_issue", 64'(start_count - s0), 64'd0);
    chk("stalled_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    wait_frame("backpressure");
    lat_rand = 0;

    // row wrap 3x3
    set_lat(3, 3, 3, 3);
    salt = 2;
    start_frame(3, 3);
    wait_frame("wrap");
    chk("wrap_out_count", 64'(out_count), 64'd9);

    // randomized frames
    lat_rand = 1; lat_lo = 1; lat_hi = 8;
    rand_ready = 1;
    for (int f = 0; f < 6; f++) begin
      salt = int'($urandom_range(4, 60));
      start_frame(int'($urandom_range(1, 7)), int'($urandom_range(1, 7)));
      wait_frame("random");
    end
    rand_ready = 0;
    lat_rand = 0;
    @(posedge clk); #1;
    out_ready = 1'b1;

    // abort after 5 issues
    set_lat(2, 40, 40, 40);
    salt = 5;
    start_frame(8, 8);
    v = 0;
    while (start_count < 5 && v < 200) begin @(negedge clk); v++; end
    chk("abort_five_issued", 64'(start_count), 64'd5);
    f0 = fd_count;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_state", 64'(top_state), 64'd0);
    exp_q.delete();
    v = 0;
    repeat (60) @(negedge clk) if (out_valid) v++;
    chk("late_done_ignored", 64'(v), 64'd0);
    chk("abort_no_frame_done", 64'(fd_count - f0), 64'd0);
    set_lat(3, 3, 3, 3);
    salt = 6;
    @(posedge clk); #1;
    start_frame(2, 2);
    chk("restart_onehot", 64'(unit_start), 64'd1);
    chk("restart_origin", 64'({unit_x[11:0], unit_y[11:0]}), 64'd0);
    wait_frame("restart");

    // abort wins over a coincident frame_start
    @(posedge clk); #1;
    x_size = 11'd2; y_size = 11'd2;
    frame_start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0; abort = 1'b0;
    chk("abort_priority_busy", 64'(busy), 64'd0);
    chk("abort_priority_start", 64'(unit_start), 64'd0);

    // zero-size frame
    f0 = fd_count;
    start_frame(0, 5);
    chk("zero_frame_done", 64'(frame_done), 64'd1);
    chk("zero_busy", 64'(busy), 64'd0);
    repeat (5) @(posedge clk); #1;
    chk("zero_no_start", 64'(start_count), 64'd0);
    chk("zero_one_pulse", 64'(fd_count - f0), 64'd1);

    // asynchronous reset mid-frame
    salt = 7;
    start_frame(6, 6);
    repeat (12) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_data", 64'(out_data), 64'd0);
    chk("arst_unit_x", 64'(unit_x), 64'd0);
    chk("arst_unit_y", 64'(unit_y), 64'd0);
    chk("arst_unit_start", 64'(unit_start), 64'd0);
    chk("arst_state", 64'(top_state), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    salt = 8;
    start_frame(2, 3);
    wait_frame("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
